// File: rtl/mac_vert_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_vert_pkg                                                          |
// | FSM state encoding and derived-width helpers for mac_unit_vert_seq.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mac_vert_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic int col_w(input int max_cols);
        return $clog2(max_cols) + 1;
    endfunction

    // Selector width: one extra bit so the value N (out of range) encodes "zero".
    function automatic int sel_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Wide enough for sum_act - psum with a full group of extreme activations.
    function automatic int part_w(input int data_width, input int group_size);
        return data_width + $clog2(group_size) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_vert_group_psum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_vert_group_psum                                                   |
// | Per-group activation muxes, adder tree and skip-zero partial select.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mac_vert_group_psum
    import mac_vert_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int GROUP_SIZE    = 8,
    parameter int SEL_PER_GROUP = GROUP_SIZE / 2,
    parameter int SEL_W         = sel_w(GROUP_SIZE),
    parameter int PART_W        = part_w(DATA_WIDTH, GROUP_SIZE)
) (
    input  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] act,
    input  logic [SEL_PER_GROUP-1:0][SEL_W-1:0]   sel,
    input  logic                                  skip_zero,
    input  logic signed [PART_W-1:0]              sum_act,
    output logic signed [PART_W-1:0]              grp_sum,
    output logic signed [PART_W-1:0]              part
);

    logic signed [PART_W-1:0] w_pick [SEL_PER_GROUP];
    logic signed [PART_W-1:0] w_psum;

    generate
        for (genvar k = 0; k < SEL_PER_GROUP; k++) begin : g_mux
            logic [DATA_WIDTH-1:0] w_a;
            // MSB set means sel >= GROUP_SIZE, which contributes zero
            assign w_a       = act[sel[k][SEL_W-2:0]];
            assign w_pick[k] = sel[k][SEL_W-1] ? '0
                             : {{(PART_W-DATA_WIDTH){w_a[DATA_WIDTH-1]}}, w_a};
        end
    endgenerate

    always_comb begin
        w_psum  = '0;
        grp_sum = '0;
        for (int k = 0; k < SEL_PER_GROUP; k++) begin
            w_psum = w_psum + w_pick[k];
        end
        for (int i = 0; i < GROUP_SIZE; i++) begin
            grp_sum = grp_sum + {{(PART_W-DATA_WIDTH){act[i][DATA_WIDTH-1]}}, act[i]};
        end
        part = skip_zero ? w_psum : (sum_act - w_psum);
    end

endmodule
`default_nettype wire

// File: rtl/mac_unit_vert_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_unit_vert_seq                                                     |
// | Bit-serial (vertical) MAC: one weight bit-column per handshake.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mac_unit_vert_seq
    import mac_vert_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int GROUP_SIZE   = 8,
    parameter int MAX_COLS     = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + 16,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   start_valid,
    output logic                                                   start_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]                  act,
    input  logic [col_w(MAX_COLS)-1:0]                             num_cols,
    input  logic                                                   load_accum,
    input  logic                                                   is_pooling,
    input  logic signed [RESULT_WIDTH-1:0]                         result_prev,
    input  logic                                                   col_valid,
    output logic                                                   col_ready,
    input  logic [(VEC_LENGTH/GROUP_SIZE)*(GROUP_SIZE/2)-1:0][sel_w(GROUP_SIZE)-1:0] act_sel,
    input  logic [(VEC_LENGTH/GROUP_SIZE)-1:0]                     is_skip_zero,
    input  logic [sel_w(VEC_LENGTH)-1:0]                           hamming_sel,
    input  logic                                                   hamming_sign,
    input  logic [2:0]                                             mul_const,
    input  logic                                                   is_shift_mul,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic signed [RESULT_WIDTH-1:0]                         result
);

    localparam int NUM_GROUPS    = VEC_LENGTH / GROUP_SIZE;
    localparam int SEL_PER_GROUP = GROUP_SIZE / 2;
    localparam int COL_W         = col_w(MAX_COLS);
    localparam int SEL_W         = sel_w(GROUP_SIZE);
    localparam int HSEL_W        = sel_w(VEC_LENGTH);
    localparam int PART_W        = part_w(DATA_WIDTH, GROUP_SIZE);

    localparam logic [COL_W-1:0] C_MAX_COLS = COL_W'(MAX_COLS);
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MAX =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MIN =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

    state_t                                   r_state;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]    r_act;
    logic [COL_W-1:0]                         r_ncols;
    logic [COL_W-1:0]                         r_cnt;
    logic                                     r_pool;
    logic signed [RESULT_WIDTH-1:0]           r_prev;
    logic signed [ACC_WIDTH-1:0]              r_acc;
    logic signed [PART_W-1:0]                 r_sum_act [NUM_GROUPS];
    logic signed [ACC_WIDTH-1:0]              r_total;
    logic                                     r_s1_valid;
    logic signed [ACC_WIDTH-1:0]              r_main;
    logic signed [ACC_WIDTH-1:0]              r_special;
    logic                                     r_drain;
    logic signed [RESULT_WIDTH-1:0]           r_result;

    logic signed [PART_W-1:0]                 w_part    [NUM_GROUPS];
    logic signed [PART_W-1:0]                 w_grp_sum [NUM_GROUPS];
    logic                                     w_col_fire;
    logic                                     w_last;
    logic signed [ACC_WIDTH-1:0]              w_main_sum;
    logic signed [ACC_WIDTH-1:0]              w_main_term;
    logic signed [ACC_WIDTH-1:0]              w_total;
    logic signed [ACC_WIDTH-1:0]              w_mulc;
    logic signed [ACC_WIDTH-1:0]              w_prod;
    logic signed [ACC_WIDTH-1:0]              w_hact;
    logic signed [ACC_WIDTH-1:0]              w_spec_raw;
    logic signed [ACC_WIDTH-1:0]              w_spec_term;
    logic [DATA_WIDTH-1:0]                    w_hsel_act;
    logic signed [RESULT_WIDTH-1:0]           w_sat;
    logic signed [RESULT_WIDTH-1:0]           w_final;

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
            mac_vert_group_psum #(
                .DATA_WIDTH    (DATA_WIDTH),
                .GROUP_SIZE    (GROUP_SIZE),
                .SEL_PER_GROUP (SEL_PER_GROUP),
                .SEL_W         (SEL_W),
                .PART_W        (PART_W)
            ) u_psum (
                .act       (r_act[g*GROUP_SIZE +: GROUP_SIZE]),
                .sel       (act_sel[g*SEL_PER_GROUP +: SEL_PER_GROUP]),
                .skip_zero (is_skip_zero[g]),
                .sum_act   (r_sum_act[g]),
                .grp_sum   (w_grp_sum[g]),
                .part      (w_part[g])
            );
        end
    endgenerate

    assign w_col_fire = (r_state == ST_RUN) && col_valid;
    assign w_last     = (r_cnt == (r_ncols - 1'b1));
    assign w_hsel_act = r_act[hamming_sel[HSEL_W-2:0]];

    always_comb begin
        w_main_sum = '0;
        w_total    = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            w_main_sum = w_main_sum + {{(ACC_WIDTH-PART_W){w_part[g][PART_W-1]}}, w_part[g]};
            w_total    = w_total + {{(ACC_WIDTH-PART_W){w_grp_sum[g][PART_W-1]}}, w_grp_sum[g]};
        end
        // The most significant weight column carries negative weight (two's complement).
        w_main_term = (w_last ? -w_main_sum : w_main_sum) <<< r_cnt;

        w_mulc      = {{(ACC_WIDTH-3){1'b0}}, mul_const};
        w_prod      = r_total * w_mulc;
        w_hact      = hamming_sel[HSEL_W-1] ? '0
                    : {{(ACC_WIDTH-DATA_WIDTH){w_hsel_act[DATA_WIDTH-1]}}, w_hsel_act};
        w_spec_raw  = (is_shift_mul ? (w_prod <<< 3) : w_prod) + w_hact;
        w_spec_term = (hamming_sign ? -w_spec_raw : w_spec_raw) <<< r_cnt;

        if (r_acc > C_SAT_MAX) begin
            w_sat = C_SAT_MAX[RESULT_WIDTH-1:0];
        end else if (r_acc < C_SAT_MIN) begin
            w_sat = C_SAT_MIN[RESULT_WIDTH-1:0];
        end else begin
            w_sat = r_acc[RESULT_WIDTH-1:0];
        end
        w_final = (r_pool && (r_prev > w_sat)) ? r_prev : w_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_act      <= '0;
            r_ncols    <= '0;
            r_cnt      <= '0;
            r_pool     <= 1'b0;
            r_prev     <= '0;
            r_acc      <= '0;
            r_total    <= '0;
            r_s1_valid <= 1'b0;
            r_main     <= '0;
            r_special  <= '0;
            r_drain    <= 1'b0;
            r_result   <= '0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                r_sum_act[g] <= '0;
            end
        end else begin
            r_s1_valid <= w_col_fire;
            if (w_col_fire) begin
                r_main    <= w_main_term;
                r_special <= w_spec_term;
            end
            if (r_s1_valid) begin
                r_acc <= r_acc + r_main + r_special;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_act   <= act;
                        r_ncols <= (num_cols > C_MAX_COLS) ? C_MAX_COLS : num_cols;
                        r_pool  <= is_pooling;
                        r_prev  <= result_prev;
                        r_acc   <= load_accum
                                 ? {{(ACC_WIDTH-RESULT_WIDTH){result_prev[RESULT_WIDTH-1]}}, result_prev}
                                 : '0;
                        r_cnt   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int g = 0; g < NUM_GROUPS; g++) begin
                        r_sum_act[g] <= w_grp_sum[g];
                    end
                    r_total <= w_total;
                    if (r_ncols == '0) begin
                        r_result <= w_final;
                        r_state  <= ST_DONE;
                    end else begin
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (col_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_drain <= 1'b0;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Second drain cycle: the final column has reached the accumulator.
                    if (r_drain) begin
                        r_result <= w_final;
                        r_state  <= ST_DONE;
                    end else begin
                        r_drain  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign col_ready   = (r_state == ST_RUN);
    assign out_valid   = (r_state == ST_DONE);
    assign result      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mac_unit_vert_seq.sv
`default_nettype none
// Directed self-checking bench for mac_unit_vert_seq (default parameters).
module tb_mac_unit_vert_seq;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start_valid;
    logic                    start_ready;
    logic [15:0][7:0]        act;
    logic [3:0]              num_cols;
    logic                    load_accum;
    logic                    is_pooling;
    logic signed [15:0]      result_prev;
    logic                    col_valid;
    logic                    col_ready;
    logic [7:0][3:0]         act_sel;
    logic [1:0]              is_skip_zero;
    logic [4:0]              hamming_sel;
    logic                    hamming_sign;
    logic [2:0]              mul_const;
    logic                    is_shift_mul;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [15:0]      result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_unit_vert_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .act          (act),
        .num_cols     (num_cols),
        .load_accum   (load_accum),
        .is_pooling   (is_pooling),
        .result_prev  (result_prev),
        .col_valid    (col_valid),
        .col_ready    (col_ready),
        .act_sel      (act_sel),
        .is_skip_zero (is_skip_zero),
        .hamming_sel  (hamming_sel),
        .hamming_sign (hamming_sign),
        .mul_const    (mul_const),
        .is_shift_mul (is_shift_mul),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic col_defaults();
        for (int k = 0; k < 8; k++) act_sel[k] = 4'd8;
        is_skip_zero = 2'b11;
        hamming_sel  = 5'd16;
        hamming_sign = 1'b0;
        mul_const    = 3'd0;
        is_shift_mul = 1'b0;
    endtask

    task automatic fill_act(input int v);
        for (int i = 0; i < 16; i++) act[i] = 8'(v);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after LOAD.
    task automatic start_job(input int n);
        num_cols    = 4'(n);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        load_accum  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_col();
        col_valid = 1'b1;
        @(negedge clk);
        col_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int expv);
        int n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk(tag, result, expv);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic job_req027(input string tag);
        for (int i = 0; i < 16; i++) act[i] = 8'(i);
        col_defaults();
        start_job(2);
        for (int j = 0; j < 4; j++) begin
            act_sel[j]     = 4'(j);
            act_sel[4 + j] = 4'(j);
        end
        is_skip_zero = 2'b11;
        send_col();
        col_defaults();
        is_skip_zero = 2'b00;
        send_col();
        col_defaults();
        wait_out(tag, -196);
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        col_valid   = 1'b0;
        out_ready   = 1'b0;
        load_accum  = 1'b0;
        is_pooling  = 1'b0;
        result_prev = '0;
        num_cols    = '0;
        fill_act(0);
        col_defaults();
        repeat (3) @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 1);
        chk("rst_col_ready", 32'(col_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", result, 0);
        reset = 1'b0;

        // Column strobes in IDLE must not move the FSM
        col_valid = 1'b1;
        @(negedge clk);
        col_valid = 1'b0;
        chk("idle_col_ignored", 32'(start_ready), 1);
        chk("idle_col_ready", 32'(col_ready), 0);

        // Trivial job: zero result, latency three edges including the handshake edge
        fill_act(1);
        col_defaults();
        start_job(1);
        chk("run_col_ready", 32'(col_ready), 1);
        chk("run_start_ready", 32'(start_ready), 0);
        send_col();
        chk("lat_e0", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_e1", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_e2", 32'(out_valid), 1);
        chk("zero_result", result, 0);
        @(negedge clk);
        chk("done_hold_valid", 32'(out_valid), 1);
        chk("done_hold_result", result, 0);
        out_ready   = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        out_ready   = 1'b0;
        start_valid = 1'b0;
        chk("done_to_idle", 32'(start_ready), 1);
        chk("done_out_low", 32'(out_valid), 0);
        @(negedge clk);
        chk("same_cycle_start_rejected", 32'(start_ready), 1);

        job_req027("two_col_msb");

        // num_cols == 0 with preload goes straight to DONE
        result_prev = 16'sd100;
        load_accum  = 1'b1;
        start_job(0);
        chk("zero_cols_valid", 32'(out_valid), 1);
        wait_out("zero_cols_result", 100);

        // Pooling: job value 30 loses to 50, job value 70 wins
        is_pooling  = 1'b1;
        result_prev = 16'sd50;
        fill_act(0);
        act[0] = 8'd30;
        col_defaults();
        hamming_sel = 5'd0;
        start_job(1);
        send_col();
        wait_out("pool_keep_prev", 50);
        act[0] = 8'd70;
        start_job(1);
        send_col();
        wait_out("pool_take_job", 70);
        is_pooling  = 1'b0;
        result_prev = '0;

        // mul_const without shift: total 16 * 3
        fill_act(1);
        col_defaults();
        mul_const = 3'd3;
        start_job(1);
        send_col();
        wait_out("mul_noshift", 48);

        // Saturation both ways: 8970 * 255 per sign
        fill_act(10);
        col_defaults();
        mul_const    = 3'd7;
        is_shift_mul = 1'b1;
        hamming_sel  = 5'd0;
        start_job(8);
        for (int c = 0; c < 8; c++) send_col();
        wait_out("sat_pos", 32767);
        hamming_sign = 1'b1;
        start_job(8);
        for (int c = 0; c < 8; c++) send_col();
        wait_out("sat_neg", -32768);

        // num_cols above MAX_COLS clamps to 8: sum of 1<<c for c=0..7
        fill_act(1);
        col_defaults();
        hamming_sel = 5'd0;
        start_job(12);
        for (int c = 0; c < 8; c++) send_col();
        wait_out("clamp_cols", 255);

        // Reset mid-job aborts cleanly
        fill_act(5);
        col_defaults();
        hamming_sel = 5'd0;
        start_job(5);
        for (int c = 0; c < 3; c++) send_col();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_start_ready", 32'(start_ready), 1);
        chk("abort_col_ready", 32'(col_ready), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_result", result, 0);
        job_req027("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mac_unit_vert_seq.md
MAC_UNIT_VERT_SEQ -- requirements
Module: mac_unit_vert_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8: activation width (signed).
REQ-002 Parameter VEC_LENGTH, default 16: activations per job.
REQ-003 Parameter GROUP_SIZE, default 8: activations per group; NUM_GROUPS = VEC_LENGTH/GROUP_SIZE; SEL_PER_GROUP = GROUP_SIZE/2.
REQ-004 Parameter MAX_COLS, default 8: maximum weight bit-columns per job; COL_W = $clog2(MAX_COLS)+1.
REQ-005 Parameters ACC_WIDTH (default DATA_WIDTH+16) and RESULT_WIDTH (default 2*DATA_WIDTH).
REQ-006 Ports: clk in 1, rising-edge clock; reset in 1, reset; one clock; reset is synchronous and active-high.
REQ-007 start_valid in 1 / start_ready out 1: job handshake; act in VEC_LENGTH x DATA_WIDTH; num_cols in COL_W; load_accum in 1; is_pooling in 1; result_prev in RESULT_WIDTH signed.
REQ-008 col_valid in 1 / col_ready out 1: column handshake; act_sel in NUM_GROUPS*SEL_PER_GROUP x ($clog2(GROUP_SIZE)+1); is_skip_zero in NUM_GROUPS; hamming_sel in $clog2(VEC_LENGTH)+1; hamming_sign in 1; mul_const in 3 unsigned; is_shift_mul in 1.
REQ-009 out_valid out 1 / out_ready in 1; result out RESULT_WIDTH signed.

Function
REQ-010 FSM states IDLE, LOAD, RUN, DRAIN, DONE; start_ready=1 only in IDLE; col_ready=1 only in RUN; out_valid=1 only in DONE.
REQ-011 IDLE->LOAD on start handshake: latch act, num_cols, is_pooling, result_prev; accumulator = load_accum ? sign-extended result_prev : 0; column counter = 0.
REQ-012 LOAD (1 cycle): compute and register per-group sum_act[g] and total sum; ->RUN, or ->DONE if num_cols==0.
REQ-013 RUN: each column handshake consumes column index c = counter, increments counter; handshake with c==num_cols-1 ->DRAIN.
REQ-014 Group partial: psum[g] = sum of SEL_PER_GROUP muxed activations of group g; sel==GROUP_SIZE selects 0; part[g] = is_skip_zero[g] ? psum[g] : sum_act[g]-psum[g].
REQ-015 Main term = (sum of part[g]), negated when c==num_cols-1 (MSB), shifted left c.
REQ-016 Special term = (total_sum*mul_const) << (is_shift_mul ? 3 : 0), plus act[hamming_sel] (sel==VEC_LENGTH gives 0), negated if hamming_sign, shifted left c.
REQ-017 Two-stage pipeline: stage 1 registers main and special terms at the column handshake edge; stage 2 adds both into the accumulator on the next edge; all arithmetic signed, sized so no intermediate overflow before ACC_WIDTH.
REQ-018 DRAIN lasts 2 cycles then ->DONE; out_valid rises 3 edges after the last column handshake edge.
REQ-019 result = accumulator saturated to RESULT_WIDTH signed; if is_pooling, result = max(saturated accumulator, latched result_prev).
REQ-020 DONE: result and out_valid stable until out_ready; out handshake ->IDLE; start in the same cycle is not accepted.
REQ-021 col_valid outside RUN and start_valid outside IDLE are ignored, with no state change.
REQ-022 num_cols > MAX_COLS is clamped to MAX_COLS.

Reset
REQ-023 reset returns FSM to IDLE from any state, aborting the job; clears the accumulator, counter and pipeline registers; outputs out_valid=0, col_ready=0, start_ready=1, result=0 after the reset edge.

Structure
REQ-024 Package mac_vert_pkg holds the FSM state enum and the derived-width localparam functions.
REQ-025 Sub-module mac_vert_group_psum, instantiated NUM_GROUPS times: muxes plus adder tree plus skip-zero select for one group.

Verification
REQ-026 Defaults: act all 1, num_cols=1, all sel=8, skip_zero=1, mul_const=0, hamming_sel=16 -> result 0; out_valid 3 edges after column.
REQ-027 act[i]=i, num_cols=2, col0 sel {0,1,2,3}/{8,9,10,11}, skip_zero=1; col1 all sel=8, skip_zero=0 -> result 44 - (2*120) = -196.
REQ-028 load_accum=1, result_prev=100, num_cols=0 -> out_valid in DONE right after LOAD, result 100.
REQ-029 is_pooling=1, result_prev=50, job yields 30 -> result 50; the same job yields 70 -> result 70.
REQ-030 Large activations, mul_const=7, is_shift_mul=1, 8 columns -> result saturates to +32767 or -32768.
REQ-031 reset asserted in RUN after 3 columns -> IDLE, start_ready=1; the next job's result is unaffected.
